// File: rtl/future_dec_key_sched_pkg.sv
// Shared constants and FSM encoding for the FUTURE decryption-side key sequencer.
package future_pkg;
  localparam int FUTURE_ROUNDS = 10;
  localparam int FUTURE_ROT    = 5;
  localparam int FUTURE_HW     = 64;
  localparam int FUTURE_IDX_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/future_dec_key_sched_if.sv
// Key-in / round-key-out handshake bundle; slave is the sequencer, master the surrounding datapath.
interface future_dec_key_sched_if
  import future_pkg::*;
#(
  parameter int HW    = FUTURE_HW,
  parameter int IDX_W = FUTURE_IDX_W
) ();
  logic [2*HW-1:0]  key_in;
  logic             key_valid;
  logic             key_ready;
  logic [HW-1:0]    rk;
  logic [IDX_W-1:0] rk_idx;
  logic             rk_valid;
  logic             rk_ready;
  logic             rk_last;
  logic             busy;

  modport master (
    output key_in, key_valid, rk_ready,
    input  key_ready, rk, rk_idx, rk_valid, rk_last, busy
  );

  modport slave (
    input  key_in, key_valid, rk_ready,
    output key_ready, rk, rk_idx, rk_valid, rk_last, busy
  );
endinterface

// File: rtl/future_dec_key_sched_rotl64.sv
// Combinational rotate-left of an HW-bit word by 0..HW-1 positions.
module future_rotl64
#(
  parameter int HW    = 64,
  parameter int AMT_W = $clog2(HW)
) (
  input  logic [HW-1:0]    din,
  input  logic [AMT_W-1:0] amt,
  output logic [HW-1:0]    dout
);
  logic [2*HW-1:0] dbl;

  // Bits shifted out of the top half re-enter from the duplicated copy below.
  assign dbl  = {din, din} << amt;
  assign dout = dbl[2*HW-1:HW];
endmodule

// File: rtl/future_dec_key_sched.sv
// Decryption-side round-key sequencer: latches K0/K1 and streams RK_ROUNDS..RK_0.
// Optional build macro FUTURE_KEY_CLEAR_EN: wipe K0/K1 once the last key is consumed.
module future_dec_key_sched
  import future_pkg::*;
#(
  parameter int ROUNDS = FUTURE_ROUNDS,
  parameter int ROT    = FUTURE_ROT,
  parameter int HW     = FUTURE_HW
) (
  input logic clk,
  input logic rst,
  future_dec_key_sched_if.slave ks
);
  localparam int AMT_W = $clog2(HW);

  if (ROT * (ROUNDS >> 1) >= HW) begin : g_bad_rot
    $error("future_dec_key_sched: ROT*(ROUNDS>>1) must be below HW");
  end
  if (ROUNDS >= (1 << FUTURE_IDX_W)) begin : g_bad_rounds
    $error("future_dec_key_sched: ROUNDS does not fit rk_idx");
  end

  state_t                  state, state_nxt;
  logic [HW-1:0]           k0, k1;
  logic [FUTURE_IDX_W-1:0] idx, rot_sel;
  logic [HW-1:0]           rot_din, rot_dout;
  logic [AMT_W-1:0]        rot_amt;
  logic                    key_acc, rk_hs, ld_en, adv_en, fin_en;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (ks.key_valid) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_EMIT;
      ST_EMIT: if (ks.rk_valid && ks.rk_ready && idx == '0) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ks.key_ready = (state == ST_IDLE);
    ks.busy      = (state != ST_IDLE);
    key_acc      = (state == ST_IDLE) && ks.key_valid;
    ld_en        = (state == ST_LOAD);
    rk_hs        = (state == ST_EMIT) && ks.rk_valid && ks.rk_ready;
    adv_en       = rk_hs && (idx != '0);
    fin_en       = rk_hs && (idx == '0);
  end

  // The key being prepared is RK_idx on load and RK_(idx-1) on each advance.
  assign rot_sel = ld_en ? idx : idx - 1'b1;
  assign rot_din = rot_sel[0] ? k1 : k0;
  assign rot_amt = AMT_W'(ROT * int'(rot_sel >> 1));

  future_rotl64 #(.HW(HW), .AMT_W(AMT_W)) u_rotl (
    .din  (rot_din),
    .amt  (rot_amt),
    .dout (rot_dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      k0          <= '0;
      k1          <= '0;
      idx         <= '0;
      ks.rk       <= '0;
      ks.rk_idx   <= '0;
      ks.rk_valid <= 1'b0;
      ks.rk_last  <= 1'b0;
    end else begin
      if (key_acc) begin
        k0  <= ks.key_in[2*HW-1:HW];
        k1  <= ks.key_in[HW-1:0];
        idx <= FUTURE_IDX_W'(ROUNDS);
      end
      if (ld_en || adv_en) begin
        idx         <= rot_sel;
        ks.rk       <= rot_dout;
        ks.rk_idx   <= rot_sel;
        ks.rk_last  <= (rot_sel == '0);
        ks.rk_valid <= 1'b1;
      end
      if (fin_en) ks.rk_valid <= 1'b0;
`ifdef FUTURE_KEY_CLEAR_EN
      if (state == ST_DONE) begin
        k0 <= '0;
        k1 <= '0;
      end
`else
`endif
    end
  end
endmodule

// File: tb/tb_future_dec_key_sched.sv
// Directed bench for future_dec_key_sched: ordering, stalls, ignored keys, reset, wrap-around.
module tb_future_dec_key_sched;
  import future_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [63:0] exp_rk [0:10];

  always #5 clk = ~clk;

  future_dec_key_sched_if ks ();

  future_dec_key_sched dut (
    .clk (clk),
    .rst (rst),
    .ks  (ks)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rk"},       ks.rk, 64'h0);
    chk({tag, "_idx"},      64'(ks.rk_idx), 64'h0);
    chk({tag, "_vld"},      64'(ks.rk_valid), 64'h0);
    chk({tag, "_last"},     64'(ks.rk_last), 64'h0);
    chk({tag, "_busy"},     64'(ks.busy), 64'h0);
    chk({tag, "_keyready"}, 64'(ks.key_ready), 64'h1);
    chk({tag, "_k0"},       dut.k0, 64'h0);
    chk({tag, "_k1"},       dut.k1, 64'h0);
  endtask

  task automatic load_key(input logic [127:0] key);
    int n = 0;
    while (!ks.key_ready && n < 20) begin
      step();
      n++;
    end
    chk("key_ready_wait", 64'(ks.key_ready), 64'h1);
    ks.key_in    = key;
    ks.key_valid = 1'b1;
    step();
    ks.key_valid = 1'b0;
    chk("load_keyready", 64'(ks.key_ready), 64'h0);
    chk("load_busy",     64'(ks.busy), 64'h1);
    chk("load_vld",      64'(ks.rk_valid), 64'h0);
  endtask

  // Consumes one full sequence; optional stall, foreign key injection or reset at a given index.
  task automatic run_seq(input logic [127:0] key, input int stall_at, input int inject_at,
                         input int rst_at);
    ks.rk_ready = 1'b1;
    load_key(key);
    for (int i = 10; i >= 0; i--) begin
      step();
      ks.key_valid = 1'b0;
      chk("seq_vld",  64'(ks.rk_valid), 64'h1);
      chk("seq_idx",  64'(ks.rk_idx), 64'(i));
      chk("seq_rk",   ks.rk, exp_rk[i]);
      chk("seq_last", 64'(ks.rk_last), 64'(i == 0));
      if (i == stall_at) begin
        ks.rk_ready = 1'b0;
        repeat (5) begin
          step();
          chk("stall_vld", 64'(ks.rk_valid), 64'h1);
          chk("stall_idx", 64'(ks.rk_idx), 64'(i));
          chk("stall_rk",  ks.rk, exp_rk[i]);
        end
        ks.rk_ready = 1'b1;
      end
      if (i == inject_at) begin
        chk("inject_keyready", 64'(ks.key_ready), 64'h0);
        ks.key_in    = {64'hDEAD_BEEF_0BAD_F00D, 64'hFFFF_0000_FFFF_0000};
        ks.key_valid = 1'b1;
      end
      if (i == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_state("midrst");
        return;
      end
    end
    step();
    chk("done_vld",      64'(ks.rk_valid), 64'h0);
    chk("done_keyready", 64'(ks.key_ready), 64'h0);
    chk("done_busy",     64'(ks.busy), 64'h1);
    step();
    chk("idle_keyready", 64'(ks.key_ready), 64'h1);
    chk("idle_busy",     64'(ks.busy), 64'h0);
  endtask

  initial begin
    ks.key_in    = '0;
    ks.key_valid = 1'b0;
    ks.rk_ready  = 1'b1;
    // K0 = 1 on even indices, K1 = 2 on odd indices, rotated by 5*(i>>1).
    exp_rk[10] = 64'h0000_0000_0200_0000;
    exp_rk[9]  = 64'h0000_0000_0020_0000;
    exp_rk[8]  = 64'h0000_0000_0010_0000;
    exp_rk[7]  = 64'h0000_0000_0001_0000;
    exp_rk[6]  = 64'h0000_0000_0000_8000;
    exp_rk[5]  = 64'h0000_0000_0000_0800;
    exp_rk[4]  = 64'h0000_0000_0000_0400;
    exp_rk[3]  = 64'h0000_0000_0000_0040;
    exp_rk[2]  = 64'h0000_0000_0000_0020;
    exp_rk[1]  = 64'h0000_0000_0000_0002;
    exp_rk[0]  = 64'h0000_0000_0000_0001;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_reset_state("rst");

    run_seq({64'h1, 64'h2}, -1, -1, -1);
    run_seq({64'h1, 64'h2},  7, -1, -1);
    run_seq({64'h1, 64'h2}, -1,  4, -1);
    run_seq({64'h1, 64'h2}, -1, -1,  5);
    run_seq({64'h1, 64'h2}, -1, -1, -1);

    // K0 with only the MSB set exercises the wrap from bit 63.
    exp_rk[10] = 64'h0000_0000_0100_0000;
    exp_rk[8]  = 64'h0000_0000_0008_0000;
    exp_rk[6]  = 64'h0000_0000_0000_4000;
    exp_rk[4]  = 64'h0000_0000_0000_0200;
    exp_rk[2]  = 64'h0000_0000_0000_0010;
    exp_rk[0]  = 64'h8000_0000_0000_0000;
    run_seq({64'h8000_0000_0000_0000, 64'h2}, -1, -1, -1);
`ifdef FUTURE_KEY_CLEAR_EN
    chk("k0_cleared", dut.k0, 64'h0);
    chk("k1_cleared", dut.k1, 64'h0);
`else
    chk("k0_held", dut.k0, 64'h8000_0000_0000_0000);
    chk("k1_held", dut.k1, 64'h2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
